// File: rtl/ldgm_pkg.sv
// rtl/ldgm_pkg.sv - LDGM codeword geometry and streamer state encoding shared with the generator
package ldgm_pkg;

  localparam int CW_BITS = 9800;
  localparam int WORD_W  = 32;
  localparam int NWORDS  = (CW_BITS + WORD_W - 1) / WORD_W;
  localparam int IDX_W   = 9;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_t;

endpackage

// File: rtl/codeword_streamer.sv
// rtl/codeword_streamer.sv - captures a full codeword and streams it out as MSB-first words
module codeword_streamer
  import ldgm_pkg::IDX_W, ldgm_pkg::stream_state_t, ldgm_pkg::IDLE, ldgm_pkg::STREAM;
#(
  parameter int CW_BITS = ldgm_pkg::CW_BITS,
  parameter int WORD_W  = ldgm_pkg::WORD_W
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 cw_valid,
  input  logic [0:CW_BITS-1]   cw_din,
  output logic                 cw_ready,
  output logic [WORD_W-1:0]    word_out,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 word_last,
  output logic [IDX_W-1:0]     word_idx
);

  localparam int NWORDS   = (CW_BITS + WORD_W - 1) / WORD_W;
  localparam int PAD_BITS = NWORDS * WORD_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  stream_state_t       state_q, state_d;
  logic [PAD_BITS-1:0] padded;
  logic [PAD_BITS-1:0] shift_q;
  logic                capture;
  logic                xfer;
  logic                at_last;

  // Code bit 0 lands in the top bit; the tail of the last word is zero-filled.
  always_comb begin
    padded = '0;
    padded[PAD_BITS-1 -: CW_BITS] = cw_din;
  end

  assign at_last   = (word_idx == LAST_IDX);
  assign word_last = word_valid & at_last;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cw_ready   = 1'b0;
    word_valid = 1'b0;
    capture    = 1'b0;
    xfer       = 1'b0;
    case (state_q)
      IDLE: begin
        cw_ready = 1'b1;
        if (cw_valid) begin
          capture = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        word_valid = 1'b1;
        if (word_ready) begin
          xfer = 1'b1;
          if (at_last) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Word 0 is loaded straight from the input so it is ready the cycle after capture;
  // the remainder sits in a shift register that advances one word per transfer.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      shift_q  <= '0;
      word_out <= '0;
      word_idx <= '0;
    end else if (capture) begin
      word_out <= padded[PAD_BITS-1 -: WORD_W];
      shift_q  <= padded << WORD_W;
      word_idx <= '0;
    end else if (xfer && !at_last) begin
      word_out <= shift_q[PAD_BITS-1 -: WORD_W];
      shift_q  <= shift_q << WORD_W;
      word_idx <= word_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_codeword_streamer.sv
// tb/tb_codeword_streamer.sv - directed self-checking bench for codeword_streamer
module tb_codeword_streamer;

  localparam int CW_BITS = 9800;
  localparam int WORD_W  = 32;
  localparam int NWORDS  = 307;
  localparam int MAXREC  = NWORDS + 8;

  logic               clk = 1'b0;
  logic               rst_b = 1'b1;
  logic               cw_valid = 1'b0;
  logic [0:CW_BITS-1] cw_din = '0;
  logic               cw_ready;
  logic [31:0]        word_out;
  logic               word_valid;
  logic               word_ready = 1'b0;
  logic               word_last;
  logic [8:0]         word_idx;

  int checks = 0;
  int failures = 0;

  logic [31:0] got_word [0:MAXREC-1];
  int          got_idx  [0:MAXREC-1];
  logic        got_last [0:MAXREC-1];
  int          n_words, n_cycles, first_cyc, last_cyc, hold_err;
  bit          timed_out;

  codeword_streamer dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .cw_valid   (cw_valid),
    .cw_din     (cw_din),
    .cw_ready   (cw_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_last  (word_last),
    .word_idx   (word_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_word(input logic [0:CW_BITS-1] cw, input int k);
    logic [31:0] w = '0;
    for (int b = 0; b < 32; b++)
      if (32 * k + b < CW_BITS) w[31-b] = cw[32*k+b];
    return w;
  endfunction

  // Called at a negedge with the codeword to present; returns at the following negedge.
  task automatic do_capture(input logic [0:CW_BITS-1] cw);
    cw_din   = cw;
    cw_valid = 1'b1;
    @(negedge clk);
    cw_valid = 1'b0;
  endtask

  // Records every transfer until word_last; mode 0 holds ready high, mode 1 toggles it randomly.
  task automatic drain(input int mode, input int max_cycles, input int inject_at,
                       input logic [0:CW_BITS-1] inject_cw);
    bit          done = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] pw = '0;
    logic [8:0]  pi = '0;
    n_words = 0; n_cycles = 0; first_cyc = -1; last_cyc = -1; hold_err = 0; timed_out = 1'b0;
    while (!done) begin
      if (n_cycles >= max_cycles) begin
        timed_out = 1'b1;
        break;
      end
      if (prev_stall && (word_valid !== 1'b1 || word_out !== pw || word_idx !== pi)) hold_err++;
      word_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      cw_valid = (n_cycles == inject_at);
      if (n_cycles == inject_at) cw_din = inject_cw;
      if (word_valid === 1'b1 && word_ready) begin
        got_word[n_words] = word_out;
        got_idx[n_words]  = int'(word_idx);
        got_last[n_words] = word_last;
        if (first_cyc < 0) first_cyc = n_cycles;
        last_cyc = n_cycles;
        n_words++;
        if (word_last === 1'b1 || n_words >= MAXREC) done = 1'b1;
      end
      prev_stall = (word_valid === 1'b1) && !word_ready;
      pw = word_out;
      pi = word_idx;
      n_cycles++;
      @(negedge clk);
    end
    word_ready = 1'b0;
    cw_valid   = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst_b = 1'b0;
    #1;
    checks++;
    if (word_valid !== 1'b0 || word_last !== 1'b0 || cw_ready !== 1'b1 ||
        word_idx !== 9'd0 || word_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_async: valid=%b last=%b ready=%b idx=%0d out=%h need 0 0 1 0 00000000",
               word_valid, word_last, cw_ready, word_idx, word_out);
    end
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    checks++;
    if (word_valid !== 1'b0 || cw_ready !== 1'b1 || word_idx !== 9'd0) begin
      failures++;
      $display("FAIL reset_release: valid=%b ready=%b idx=%0d need 0 1 0", word_valid, cw_ready, word_idx);
    end
  endtask

  task automatic test_all_ones;
    logic [0:CW_BITS-1] cw;
    logic [31:0]        exp;
    cw = '1;
    do_capture(cw);
    checks++;
    if (word_valid !== 1'b1 || word_idx !== 9'd0 || cw_ready !== 1'b0) begin
      failures++;
      $display("FAIL ones_latency: valid=%b idx=%0d cw_ready=%b need 1 0 0", word_valid, word_idx, cw_ready);
    end
    drain(0, 1000, -1, '0);
    checks++;
    if (timed_out || n_words !== NWORDS) begin
      failures++;
      $display("FAIL ones_count: words=%0d timeout=%0d need %0d 0", n_words, timed_out, NWORDS);
    end
    checks++;
    if (first_cyc !== 0 || last_cyc !== NWORDS - 1) begin
      failures++;
      $display("FAIL ones_rate: first=%0d last=%0d need 0 %0d", first_cyc, last_cyc, NWORDS - 1);
    end
    for (int k = 0; k < n_words && k < NWORDS; k++) begin
      exp = (k == NWORDS - 1) ? 32'hFF000000 : 32'hFFFFFFFF;
      checks++;
      if (got_word[k] !== exp || got_idx[k] !== k || got_last[k] !== (k == NWORDS - 1)) begin
        failures++;
        $display("FAIL ones_word%0d: got %h idx=%0d last=%b need %h idx=%0d last=%b",
                 k, got_word[k], got_idx[k], got_last[k], exp, k, (k == NWORDS - 1));
      end
    end
    checks++;
    if (cw_ready !== 1'b1 || word_valid !== 1'b0 || word_last !== 1'b0) begin
      failures++;
      $display("FAIL ones_after_last: cw_ready=%b valid=%b last=%b need 1 0 0", cw_ready, word_valid, word_last);
    end
  endtask

  task automatic test_end_bits;
    logic [0:CW_BITS-1] cw;
    logic [31:0]        exp;
    cw = '0;
    cw[0] = 1'b1;
    cw[CW_BITS-1] = 1'b1;
    do_capture(cw);
    drain(0, 1000, -1, '0);
    checks++;
    if (timed_out || n_words !== NWORDS) begin
      failures++;
      $display("FAIL ends_count: words=%0d need %0d", n_words, NWORDS);
    end
    for (int k = 0; k < n_words && k < NWORDS; k++) begin
      exp = (k == 0) ? 32'h80000000 : (k == NWORDS - 1) ? 32'h01000000 : 32'h0;
      checks++;
      if (got_word[k] !== exp) begin
        failures++;
        $display("FAIL ends_word%0d: got %h need %h", k, got_word[k], exp);
      end
    end
  endtask

  task automatic test_random_backpressure;
    logic [0:CW_BITS-1] cw;
    logic [31:0]        exp;
    for (int i = 0; i < CW_BITS; i++) cw[i] = 1'($urandom_range(0, 1));
    do_capture(cw);
    drain(1, 5000, -1, '0);
    checks++;
    if (timed_out || n_words !== NWORDS) begin
      failures++;
      $display("FAIL rand_count: words=%0d timeout=%0d need %0d 0", n_words, timed_out, NWORDS);
    end
    checks++;
    if (hold_err !== 0) begin
      failures++;
      $display("FAIL rand_hold: stall violations=%0d need 0", hold_err);
    end
    for (int k = 0; k < n_words && k < NWORDS; k++) begin
      exp = ref_word(cw, k);
      checks++;
      if (got_word[k] !== exp || got_idx[k] !== k || got_last[k] !== (k == NWORDS - 1)) begin
        failures++;
        $display("FAIL rand_word%0d: got %h idx=%0d last=%b need %h idx=%0d",
                 k, got_word[k], got_idx[k], got_last[k], exp, k);
      end
    end
  endtask

  task automatic test_ignore_and_rearm;
    logic [0:CW_BITS-1] cw_a, cw_b;
    for (int i = 0; i < CW_BITS; i++) begin
      cw_a[i] = 1'($urandom_range(0, 1));
      cw_b[i] = ~cw_a[i];
    end
    do_capture(cw_a);
    drain(0, 1000, 50, cw_b);
    checks++;
    if (timed_out || n_words !== NWORDS) begin
      failures++;
      $display("FAIL ignore_count: words=%0d need %0d", n_words, NWORDS);
    end
    for (int k = 0; k < n_words && k < NWORDS; k++) begin
      checks++;
      if (got_word[k] !== ref_word(cw_a, k) || got_idx[k] !== k) begin
        failures++;
        $display("FAIL ignore_word%0d: got %h idx=%0d need %h idx=%0d",
                 k, got_word[k], got_idx[k], ref_word(cw_a, k), k);
      end
    end
    do_capture(cw_b);
    checks++;
    if (word_valid !== 1'b1 || word_idx !== 9'd0 || word_out !== ref_word(cw_b, 0)) begin
      failures++;
      $display("FAIL rearm_capture: valid=%b idx=%0d out=%h need 1 0 %h",
               word_valid, word_idx, word_out, ref_word(cw_b, 0));
    end
    // Scramble the input right after capture; the stream must still show cw_b.
    cw_din = cw_a;
    drain(0, 1000, -1, '0);
    checks++;
    if (timed_out || n_words !== NWORDS) begin
      failures++;
      $display("FAIL rearm_count: words=%0d need %0d", n_words, NWORDS);
    end
    for (int k = 0; k < n_words && k < NWORDS; k++) begin
      checks++;
      if (got_word[k] !== ref_word(cw_b, k)) begin
        failures++;
        $display("FAIL immune_word%0d: got %h need %h", k, got_word[k], ref_word(cw_b, k));
      end
    end
  endtask

  task automatic test_reset_mid_stream;
    logic [0:CW_BITS-1] cw_c;
    bit                 found = 1'b0;
    for (int i = 0; i < CW_BITS; i++) cw_c[i] = (i % 3 == 0);
    do_capture('1);
    word_ready = 1'b1;
    for (int c = 0; c < 400 && !found; c++) begin
      if (word_valid === 1'b1 && word_idx === 9'd100) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL midrst_reach: idx=%0d valid=%b need idx 100 valid 1", word_idx, word_valid);
    end
    word_ready = 1'b0;
    #2 rst_b = 1'b0;
    #1;
    checks++;
    if (word_valid !== 1'b0 || word_last !== 1'b0 || cw_ready !== 1'b1 || word_idx !== 9'd0) begin
      failures++;
      $display("FAIL midrst_async: valid=%b last=%b ready=%b idx=%0d need 0 0 1 0",
               word_valid, word_last, cw_ready, word_idx);
    end
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    checks++;
    if (word_valid !== 1'b0 || cw_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_quiet: valid=%b ready=%b need 0 1", word_valid, cw_ready);
    end
    do_capture(cw_c);
    drain(0, 1000, -1, '0);
    checks++;
    if (timed_out || n_words !== NWORDS || got_idx[0] !== 0) begin
      failures++;
      $display("FAIL midrst_restream: words=%0d first_idx=%0d need %0d 0", n_words, got_idx[0], NWORDS);
    end
    for (int k = 0; k < n_words && k < NWORDS; k++) begin
      checks++;
      if (got_word[k] !== ref_word(cw_c, k)) begin
        failures++;
        $display("FAIL midrst_word%0d: got %h need %h", k, got_word[k], ref_word(cw_c, k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_end_bits();
    test_random_backpressure();
    test_ignore_and_rearm();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
